// File: rtl/frame_reader_pkg.sv
// Shared constants and types for the frame reader: state encoding and
// the pixel word carried through the output skid buffer.
package frame_reader_pkg;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int FRAME_W_DEF = 256;
  localparam int FRAME_H_DEF = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    COPY  = 3'd2,
    SCAN  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] data;
  } pix_t;
endpackage

// File: rtl/frame_reader_pix_skid.sv
// Two-entry valid/ready skid buffer for tagged pixels; almost_full tells the
// address issuer whether a word launched this cycle will still find room.
module pix_skid
  import frame_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  pix_t in_pix,
  input  logic out_ready,
  output logic out_valid,
  output pix_t out_pix,
  output logic almost_full
);

  logic [1:0] count;
  logic [2:0] occ_next;
  logic       pop;
  pix_t       ent0;
  pix_t       ent1;

  assign out_valid = (count != 2'd0);
  assign out_pix   = ent0;
  assign pop       = out_valid && out_ready;
  // Occupancy after this edge; a word issued now arrives next cycle.
  assign occ_next    = {1'b0, count} + {2'b00, in_valid} - {2'b00, pop};
  assign almost_full = (occ_next >= 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      count <= occ_next[1:0];
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_pix;
          else               ent1 <= in_pix;
        end
        2'b01: ent0 <= ent1;
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_pix;
          end else begin
            ent0 <= ent1;
            ent1 <= in_pix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Frame reader: requests a buffer snapshot, then scans it out as a pixel stream.
// Optional REQ watchdog enabled by defining FRAME_READER_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for start with buffer idle
//   REQ   | r_rd high, waiting for buffer to go busy
//   COPY  | r_rd high, waiting for snapshot complete
//   SCAN  | issuing read addresses 0..W*H-1
//   DRAIN | flushing remaining pixels until eof transfers
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic              r_clk,
  input  logic              rst,
  input  logic              start,
  output logic              r_rd,
  input  logic              r_done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] d_out_a,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [7:0]        COL_LAST  = 8'(FRAME_W - 1);
  localparam logic [7:0]        ROW_LAST  = 8'(FRAME_H - 1);

  state_t     state;
  state_t     state_nxt;
  logic       issue;
  logic       last_addr;
  logic [7:0] col;
  logic [7:0] row;
  logic       fly_valid;
  logic [2:0] fly_flags;
  pix_t       fly_pix;
  pix_t       out_pix;
  logic       almost_full;

`ifdef FRAME_READER_TIMEOUT_EN
  logic [3:0] wd;
  logic       timeout;
`endif

  assign last_addr = (r_addr == ADDR_LAST);

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef FRAME_READER_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state)
      IDLE:  if (start && r_done) state_nxt = REQ;
      REQ: begin
        if (!r_done) state_nxt = COPY;
`ifdef FRAME_READER_TIMEOUT_EN
        else if (wd == 4'hF) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
`endif
      end
      COPY:  if (r_done) state_nxt = SCAN;
      SCAN:  if (issue && last_addr) state_nxt = DRAIN;
      DRAIN: if (pix_valid && pix_ready && eof) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r_rd  = (state == REQ) || (state == COPY);
    busy  = (state != IDLE);
    issue = (state == SCAN) && !almost_full;
  end

  // Address and position counters; flags travel with the word in flight.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      col       <= 8'd0;
      row       <= 8'd0;
      fly_valid <= 1'b0;
      fly_flags <= 3'b000;
    end else begin
      fly_valid <= issue;
      if (issue)
        fly_flags <= {r_addr == '0, col == COL_LAST,
                      (col == COL_LAST) && (row == ROW_LAST)};
      if (state == IDLE) begin
        r_addr <= '0;
        col    <= 8'd0;
        row    <= 8'd0;
      end else if (issue) begin
        if (!last_addr) r_addr <= r_addr + 16'd1;
        col <= (col == COL_LAST) ? 8'd0 : col + 8'd1;
        if (col == COL_LAST) row <= (row == ROW_LAST) ? 8'd0 : row + 8'd1;
      end
    end
  end

  assign fly_pix = {fly_flags, d_out_a};

  pix_skid u_skid (
    .clk         (r_clk),
    .rst         (rst),
    .in_valid    (fly_valid),
    .in_pix      (fly_pix),
    .out_ready   (pix_ready),
    .out_valid   (pix_valid),
    .out_pix     (out_pix),
    .almost_full (almost_full)
  );

  assign pix_data = out_pix.data;
  assign sof      = pix_valid && out_pix.sof;
  assign eol      = pix_valid && out_pix.eol;
  assign eof      = pix_valid && out_pix.eof;

`ifdef FRAME_READER_TIMEOUT_EN
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      wd  <= 4'd0;
      err <= 1'b0;
    end else begin
      err <= timeout;
      wd  <= (state == REQ) ? wd + 4'd1 : 4'd0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a 4x2 instance and a default 256x256 instance, each
// fed by a behavioural frame buffer; pixels are checked against a frame model.
module tb_frame_reader;
  localparam int SW = 4;
  localparam int SH = 2;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] data;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  px_t got_q[$];
  px_t exp_q[$];

  // small instance and its buffer model
  logic        start_s = 1'b0, pready_s = 1'b1, force_low_s = 1'b0, hold_s = 1'b0;
  logic        rd_s, done_s, dmdl_s, rdq_s, dcnt_s;
  logic [15:0] addr_s, dout_s, pdata_s;
  logic        pvalid_s, sof_s, eol_s, eof_s, busy_s, err_s;
  int          low_n_s = 3;
  int          lcnt_s;

  assign done_s = dmdl_s && !force_low_s;

  always @(posedge clk) begin
    rdq_s  <= rd_s;
    dout_s <= addr_s + 16'h0100;
    if (rst) begin
      dmdl_s <= 1'b1;
      dcnt_s <= 1'b0;
      lcnt_s <= 0;
    end else if (rd_s && !rdq_s && !hold_s) begin
      dcnt_s <= 1'b1;
    end else if (dcnt_s) begin
      dcnt_s <= 1'b0;
      dmdl_s <= 1'b0;
      lcnt_s <= low_n_s;
    end else if (lcnt_s != 0) begin
      lcnt_s <= lcnt_s - 1;
      if (lcnt_s == 1) dmdl_s <= 1'b1;
    end
  end

  frame_reader #(.FRAME_W(SW), .FRAME_H(SH)) dut_s (
    .r_clk(clk), .rst(rst), .start(start_s), .r_rd(rd_s), .r_done(done_s),
    .r_addr(addr_s), .d_out_a(dout_s), .pix_data(pdata_s), .pix_valid(pvalid_s),
    .pix_ready(pready_s), .sof(sof_s), .eol(eol_s), .eof(eof_s),
    .busy(busy_s), .err(err_s)
  );

  // default-size instance and its buffer model
  logic        start_l = 1'b0, pready_l = 1'b1;
  logic        rd_l, dmdl_l, rdq_l, dcnt_l;
  logic [15:0] addr_l, dout_l, pdata_l;
  logic        pvalid_l, sof_l, eol_l, eof_l, busy_l, err_l;
  int          lcnt_l;

  always @(posedge clk) begin
    rdq_l  <= rd_l;
    dout_l <= addr_l + 16'h0100;
    if (rst) begin
      dmdl_l <= 1'b1;
      dcnt_l <= 1'b0;
      lcnt_l <= 0;
    end else if (rd_l && !rdq_l) begin
      dcnt_l <= 1'b1;
    end else if (dcnt_l) begin
      dcnt_l <= 1'b0;
      dmdl_l <= 1'b0;
      lcnt_l <= 3;
    end else if (lcnt_l != 0) begin
      lcnt_l <= lcnt_l - 1;
      if (lcnt_l == 1) dmdl_l <= 1'b1;
    end
  end

  frame_reader dut_l (
    .r_clk(clk), .rst(rst), .start(start_l), .r_rd(rd_l), .r_done(dmdl_l),
    .r_addr(addr_l), .d_out_a(dout_l), .pix_data(pdata_l), .pix_valid(pvalid_l),
    .pix_ready(pready_l), .sof(sof_l), .eol(eol_l), .eof(eof_l),
    .busy(busy_l), .err(err_l)
  );

  function automatic void build_exp(input int w, input int h);
    exp_q.delete();
    for (int i = 0; i < w * h; i++)
      exp_q.push_back({i == 0, (i % w) == w - 1, i == w * h - 1, 16'(i + 'h100)});
  endfunction

  // Runs one small-frame read; mode 0 ready=1, 1 toggling, 2 random.
  task automatic run_small(input int mode, input int inject, input int abort_n,
                           output int rd_cycles, output int gap, output int span,
                           output int stab_err, output int busy_after);
    int   scan_cyc = -1, first_v = -1, last_x = -1;
    logic prev_rd = 1'b0, prev_stall = 1'b0, eof_seen = 1'b0;
    px_t  prev_px = '0, cur;
    got_q.delete();
    rd_cycles = 0; stab_err = 0; busy_after = -1; gap = -1; span = -1;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cur = {sof_s, eol_s, eof_s, pdata_s};
      if (eof_seen) begin
        busy_after = int'(busy_s);
        break;
      end
      if (abort_n > 0 && got_q.size() >= abort_n) break;
      if (rd_s) rd_cycles++;
      if (prev_rd && !rd_s && busy_s) scan_cyc = cyc;
      if (pvalid_s && first_v < 0) first_v = cyc;
      if (prev_stall && (!pvalid_s || cur !== prev_px)) stab_err++;
      start_s = (inject != 0 && cyc == scan_cyc);
      case (mode)
        0:       pready_s = 1'b1;
        1:       pready_s = (cyc % 2 == 0);
        default: pready_s = 1'($urandom_range(0, 1));
      endcase
      if (pvalid_s && pready_s) begin
        got_q.push_back(cur);
        last_x = cyc;
        if (cur.eof) eof_seen = 1'b1;
      end
      prev_stall = pvalid_s && !pready_s;
      prev_px    = cur;
      prev_rd    = rd_s;
      @(negedge clk);
    end
    start_s  = 1'b0;
    pready_s = 1'b1;
    if (scan_cyc >= 0 && first_v >= 0) gap = first_v - scan_cyc;
    if (first_v >= 0 && last_x >= 0) span = last_x - first_v;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_s, addr_s, pvalid_s, sof_s, eol_s, eof_s, busy_s, err_s} !== '0) begin
      failures++;
      $display("FAIL reset_small got rd=%b addr=%h v=%b sof=%b eol=%b eof=%b busy=%b err=%b exp all 0",
               rd_s, addr_s, pvalid_s, sof_s, eol_s, eof_s, busy_s, err_s);
    end
    checks++;
    if ({rd_l, addr_l, pvalid_l, sof_l, eol_l, eof_l, busy_l, err_l} !== '0) begin
      failures++;
      $display("FAIL reset_large got rd=%b addr=%h v=%b busy=%b err=%b exp all 0",
               rd_l, addr_l, pvalid_l, busy_l, err_l);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_s, pvalid_s, busy_s} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got rd=%b v=%b busy=%b exp 000", rd_s, pvalid_s, busy_s);
    end
  endtask

  task automatic test_basic();
    int rdc, gap, span, stab, ba, bad;
    low_n_s = int'($urandom_range(1, 6));
    build_exp(SW, SH);
    run_small(0, 0, 0, rdc, gap, span, stab, ba);
    // r_rd spans the 2-cycle drop delay, the low period, and the return cycle
    checks++;
    if (rdc != low_n_s + 3) begin
      failures++;
      $display("FAIL basic_rd_cycles got=%0d exp=%0d", rdc, low_n_s + 3);
    end
    checks++;
    if (gap != 2) begin
      failures++;
      $display("FAIL basic_first_latency got=%0d exp=2", gap);
    end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_pixels first_bad=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (span != SW * SH - 1) begin
      failures++;
      $display("FAIL basic_throughput got_span=%0d exp=%0d", span, SW * SH - 1);
    end
    checks++;
    if (ba != 0) begin
      failures++;
      $display("FAIL basic_busy_after got=%0d exp=0", ba);
    end
  endtask

  task automatic test_stall();
    int rdc, gap, span, stab, ba, bad;
    low_n_s = int'($urandom_range(1, 6));
    build_exp(SW, SH);
    run_small(1, 0, 0, rdc, gap, span, stab, ba);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stall_pixels first_bad=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (stab != 0) begin
      failures++;
      $display("FAIL stall_stability got_changes=%0d exp=0", stab);
    end
    checks++;
    if (ba != 0) begin
      failures++;
      $display("FAIL stall_busy_after got=%0d exp=0", ba);
    end
  endtask

  task automatic test_random_ready();
    int rdc, gap, span, stab, ba, bad;
    for (int it = 0; it < 3; it++) begin
      low_n_s = int'($urandom_range(1, 8));
      build_exp(SW, SH);
      run_small(2, 0, 0, rdc, gap, span, stab, ba);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
      checks++;
      if (bad >= 0 || got_q.size() != exp_q.size() || stab != 0 || ba != 0) begin
        failures++;
        $display("FAIL random_ready_%0d first_bad=%0d got_n=%0d exp_n=%0d stab=%0d busy_after=%0d",
                 it, bad, got_q.size(), exp_q.size(), stab, ba);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int rdc, gap, span, stab, ba, bad, viol;
    force_low_s = 1'b1;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_s || busy_s) viol++;
      @(negedge clk);
    end
    force_low_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rd_s || busy_s) viol++;
      @(negedge clk);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL ignore_start_idle got_active_cycles=%0d exp=0", viol);
    end
    build_exp(SW, SH);
    run_small(0, 1, 0, rdc, gap, span, stab, ba);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0 || got_q.size() != exp_q.size() || ba != 0) begin
      failures++;
      $display("FAIL ignore_start_scan_pixels first_bad=%0d got_n=%0d exp_n=%0d busy_after=%0d",
               bad, got_q.size(), exp_q.size(), ba);
    end
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_s || busy_s || pvalid_s) viol++;
      @(negedge clk);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL ignore_start_scan_after got_active_cycles=%0d exp=0", viol);
    end
  endtask

  task automatic test_reset_mid();
    int rdc, gap, span, stab, ba, bad, viol;
    low_n_s = 2;
    run_small(0, 0, 3, rdc, gap, span, stab, ba);
    checks++;
    if (busy_s !== 1'b1 || got_q.size() != 3) begin
      failures++;
      $display("FAIL reset_mid_pre got busy=%b pixels=%0d exp busy=1 pixels=3", busy_s, got_q.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_s, addr_s, pvalid_s, sof_s, eol_s, eof_s, busy_s, err_s} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got rd=%b addr=%h v=%b sof=%b eol=%b eof=%b busy=%b err=%b exp all 0",
               rd_s, addr_s, pvalid_s, sof_s, eol_s, eof_s, busy_s, err_s);
    end
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      if (pvalid_s || busy_s) viol++;
      @(negedge clk);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet got_active_cycles=%0d exp=0", viol);
    end
    build_exp(SW, SH);
    run_small(0, 0, 0, rdc, gap, span, stab, ba);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_mid_refetch first_bad=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int rdc = 0, errs = 0, err_cyc = -1;
    logic busy_at_err = 1'b1;
    hold_s = 1'b1;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rd_s) rdc++;
      if (err_s) begin
        errs++;
        if (err_cyc < 0) begin
          err_cyc = cyc;
          busy_at_err = busy_s;
        end
      end
      @(negedge clk);
    end
`ifdef FRAME_READER_TIMEOUT_EN
    checks++;
    if (rdc != 16 || errs != 1 || err_cyc != 16 || busy_at_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got rd_cycles=%0d errs=%0d err_cyc=%0d busy=%b exp 16 1 16 0",
               rdc, errs, err_cyc, busy_at_err);
    end
`else
    checks++;
    if (rdc != 40 || errs != 0) begin
      failures++;
      $display("FAIL timeout_disabled got rd_cycles=%0d errs=%0d exp 40 0", rdc, errs);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    hold_s = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int idx = 0, errs = 0, dec = 0;
    logic [15:0] prev = 16'h0000;
    px_t last = '0;
    logic seen_eof = 1'b0;
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    for (int cyc = 0; cyc < 70000 && !seen_eof; cyc++) begin
      if (pvalid_l) begin
        if ({sof_l, eol_l, eof_l, pdata_l} !==
            {idx == 0, (idx % 256) == 255, idx == 65535, 16'(idx + 'h100)}) errs++;
        if (eof_l) begin
          seen_eof = 1'b1;
          last = {sof_l, eol_l, eof_l, pdata_l};
        end
        idx++;
      end
      if (busy_l && !rd_l) begin
        if (addr_l < prev) dec++;
        prev = addr_l;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != 65536 || errs != 0) begin
      failures++;
      $display("FAIL full_frame_pixels got_n=%0d bad=%0d exp_n=65536 bad=0", idx, errs);
    end
    checks++;
    if (last.data !== 16'h00FF || last.eof !== 1'b1 || last.eol !== 1'b1) begin
      failures++;
      $display("FAIL full_frame_last got data=%h eol=%b eof=%b exp 00ff 1 1", last.data, last.eol, last.eof);
    end
    checks++;
    if (dec != 0) begin
      failures++;
      $display("FAIL full_frame_addr_wrap got_decreases=%0d exp=0", dec);
    end
    checks++;
    if (busy_l !== 1'b0) begin
      failures++;
      $display("FAIL full_frame_busy_after got=%b exp=0", busy_l);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random_ready();
    test_ignore_start();
    test_reset_mid();
    test_timeout();
    test_full_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 SHALL have parameter FRAME_W, default 256, pixels per line (1..256).
REQ-002 SHALL have parameter FRAME_H, default 256, lines per frame (1..256); FRAME_W*FRAME_H SHALL be at most 65536.
REQ-003 SHALL have port r_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle frame-read request.
REQ-006 SHALL have port r_rd  output  1  snapshot request to the frame buffer.
REQ-007 SHALL have port r_done  input  1  buffer snapshot-complete flag; 1 means idle or complete.
REQ-008 SHALL have port r_addr  output  16  buffer read address.
REQ-009 SHALL have port d_out_a  input  16  buffer read data, valid one cycle after r_addr.
REQ-010 SHALL have ports pix_data output 16, pix_valid output 1, pix_ready input 1: pixel stream.
REQ-011 SHALL have ports sof, eol, eof, all output 1: first pixel, last pixel of line, last pixel of frame; qualified by pix_valid.
REQ-012 SHALL have ports busy output 1 (state not IDLE) and err output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, REQ, COPY, SCAN, DRAIN.
REQ-014 IDLE: start=1 with r_done=1 -> REQ; start with r_done=0, or start in any other state, SHALL be ignored.
REQ-015 REQ: r_rd=1; r_done=0 -> COPY.
REQ-016 COPY: r_rd=1; r_done=1 -> SCAN, with r_rd=0 from the SCAN cycle on.
REQ-017 SCAN: r_addr SHALL step linearly from 0 to FRAME_W*FRAME_H-1, one address per cycle, only while the output buffer has room for the in-flight word; after the last address -> DRAIN.
REQ-018 Each issued address SHALL yield exactly one pixel: d_out_a captured one cycle later, in address order, with no drop or duplicate.
REQ-019 Handshake: a pixel transfers when pix_valid and pix_ready are both 1; pix_data/sof/eol/eof SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-020 sof SHALL be 1 only on address 0; eol on column FRAME_W-1 of every line; eof on the final pixel (eol also 1).
REQ-021 Column and row counters SHALL wrap at FRAME_W and FRAME_H; the address SHALL NOT wrap within a frame.
REQ-022 DRAIN: -> IDLE in the cycle after the eof pixel transfers.
REQ-023 With pix_ready held 1, throughput SHALL be one pixel per cycle; first pix_valid SHALL come 2 cycles after entering SCAN.
REQ-024 r_rd SHALL be 0 in IDLE, SCAN and DRAIN.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, r_rd=0, r_addr=0, pix_valid=0, sof=eol=eof=0, busy=0, err=0, counters 0, output buffer empty.
REQ-026 Reset mid-frame SHALL discard all in-flight pixels; no pixel SHALL emerge after reset until a new start.

Configuration
REQ-027 With FRAME_READER_TIMEOUT_EN defined, a 4-bit watchdog SHALL count cycles in REQ; if r_done is still 1 after 16 cycles, the block SHALL drop r_rd, pulse err for one cycle and return to IDLE.
REQ-028 Without FRAME_READER_TIMEOUT_EN, REQ SHALL wait indefinitely and err SHALL be tied 0.

Structure
REQ-029 Package frame_reader_pkg SHALL hold the state enum, ADDR_W=16, DATA_W=16 and the default FRAME_W/FRAME_H.
REQ-030 The output buffer SHALL be sub-module pix_skid: a 2-entry valid/ready skid buffer carrying {sof,eol,eof,data}, plus an almost-full output used to gate address issue.

Verification (bench uses a behavioural buffer: r_done drops 2 cycles after r_rd rises and returns after N cycles; d_out_a = address+0x100, 1-cycle latency)
REQ-031 FRAME_W=4, FRAME_H=2, pix_ready=1, start -> r_rd high until r_done returns, then 8 pixels 0x100..0x107 on consecutive cycles; sof on 0x100, eol on 0x103 and 0x107, eof on 0x107; busy drops the next cycle.
REQ-032 Same frame with pix_ready toggling 1/0 every cycle -> identical 8-pixel sequence, data stable during stalls, no loss or duplicate.
REQ-033 start pulsed during SCAN, and start with r_done=0 in IDLE -> ignored; r_rd stays 0.
REQ-034 rst asserted during SCAN after 3 pixels -> all outputs go to reset values at once; a new start yields a full frame from 0x100.
REQ-035 FRAME_READER_TIMEOUT_EN defined, buffer model never drops r_done -> r_rd falls and err pulses exactly once 16 cycles into REQ, state IDLE; without the macro, r_rd stays high and err stays 0.
REQ-036 Default 256x256 frame, pix_ready=1 -> 65536 pixels; last is 0x100+0xFFFF truncated to 16 bits (0x00FF) with eof=1; r_addr never exceeds 0xFFFF.
